md_unit: RTL and testbench

Execute-stage multiply/divide unit holding the HI/LO register pair for the 5-stage MIPS pipeline. It consumes the already-forwarded E-stage rs/rt operands, runs multi-cycle mult/multu/div/divu, and performs mthi/mtlo writes. It reports a busy status and raises a stall request to the D-stage hazard logic whenever a decode-stage HI/LO user would collide with an in-flight operation.

---
 rtl/md_unit.sv | 156 +++++++++++++++
 tb/tb_md_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit
//  Purpose  : E-stage multiply/divide unit owning the HI/LO register pair.
//             Runs multi-cycle mult/multu/div/divu, performs mthi/mtlo and
//             raises a D-stage stall while an operation is in flight.
//  Option   : MD_MADD_EN - when defined, op 7 is a signed multiply-accumulate
//             into {hi,lo}; otherwise op 7 behaves as op 0.
//  Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
  localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

  state_t      state_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        res_we_q, res_we_d;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;

  logic        w_madd;
  logic        w_long;
  logic [63:0] w_smul, w_umul, w_acc;
  logic [31:0] w_a_mag, w_b_mag, w_dvs, w_q_mag, w_r_mag, w_sq, w_sr;
  logic [31:0] w_udvs, w_uq, w_ur;

`ifdef MD_MADD_EN
  assign w_madd = (op == 3'd7);
`else
  assign w_madd = 1'b0;
`endif

  // Ops that occupy the unit for several cycles.
  assign w_long = (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || w_madd;

  // Low 64 bits of a product are the same for signed and unsigned operands
  // once the inputs are extended appropriately.
  assign w_smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign w_umul = {32'd0, a} * {32'd0, b};
  assign w_acc  = {hi_q, lo_q} + w_smul;

  // Signed division is done on magnitudes so that 0x80000000 / -1 wraps
  // cleanly instead of relying on simulator overflow behaviour. A zero
  // divisor is replaced by 1 only to keep the divider defined; its result
  // is never written back.
  assign w_a_mag = a[31] ? (~a + 32'd1) : a;
  assign w_b_mag = b[31] ? (~b + 32'd1) : b;
  assign w_dvs   = (b == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag = w_a_mag / w_dvs;
  assign w_r_mag = w_a_mag % w_dvs;
  assign w_sq    = (a[31] ^ b[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_sr    = a[31] ? (~w_r_mag + 32'd1) : w_r_mag;
  assign w_udvs  = (b == 32'd0) ? 32'd1 : b;
  assign w_uq    = a / w_udvs;
  assign w_ur    = a % w_udvs;

  // Candidate pending result and latency for the op presented this cycle.
  always_comb begin
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_we_d = 1'b1;
    cnt_d    = c_mult_cnt;
    case (op)
      3'd1:    {res_hi_d, res_lo_d} = w_smul;
      3'd2:    {res_hi_d, res_lo_d} = w_umul;
      3'd3: begin
        res_hi_d = w_sr;
        res_lo_d = w_sq;
        res_we_d = (b != 32'd0);
        cnt_d    = c_div_cnt;
      end
      3'd4: begin
        res_hi_d = w_ur;
        res_lo_d = w_uq;
        res_we_d = (b != 32'd0);
        cnt_d    = c_div_cnt;
      end
      3'd7:    {res_hi_d, res_lo_d} = w_acc;
      default: ;
    endcase
  end

  // Control FSM, latency counter, pending result and the HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      res_we_q <= 1'b0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (w_long) begin
              res_hi_q <= res_hi_d;
              res_lo_q <= res_lo_d;
              res_we_q <= res_we_d;
              cnt_q    <= cnt_d;
              busy_q   <= 1'b1;
              state_q  <= S_RUN;
            end else if (op == 3'd5) begin
              hi_q <= a;
            end else if (op == 3'd6) begin
              lo_q <= a;
            end
          end
        end
        S_RUN: begin
          if (cnt_q == 4'd1) begin
            if (res_we_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = d_uses_md && (busy_q || (start && w_long));

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_unit
//  Purpose  : Self-checking bench for md_unit against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;

  localparam int NM = 5;
  localparam int ND = 10;
`ifdef MD_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        d_uses_md;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  bit          m_we;
  int          m_left;

  md_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .d_uses_md(d_uses_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_long(input logic [2:0] o);
    return (o >= 3'd1 && o <= 3'd4) || (o == 3'd7 && MADD);
  endfunction

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_res = 0; m_we = 0; m_left = 0;
  endtask

  // Apply one cycle of inputs, check stall, clock, update model, check state.
  task automatic step(input bit s, input logic [2:0] o, input logic [31:0] x,
                      input logic [31:0] y, input bit d);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    start = s; op = o; a = x; b = y; d_uses_md = d;
    #1;
    chk("stall", {63'd0, stall}, {63'd0, d && (m_left > 0 || (s && is_long(o)))});
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_we) {m_hi, m_lo} = m_res;
    end else if (s) begin
      sa = longint'($signed(x)); sb = longint'($signed(y));
      ua = x; ub = y;
      m_we = 1'b1;
      case (o)
        3'd1: begin m_res = sa * sb; m_left = NM; end
        3'd2: begin m_res = ua * ub; m_left = NM; end
        3'd3: begin
          m_left = ND;
          if (y == 0) m_we = 1'b0;
          else begin q = sa / sb; r = sa % sb; m_res = {r[31:0], q[31:0]}; end
        end
        3'd4: begin
          m_left = ND;
          if (y == 0) m_we = 1'b0;
          else m_res = {32'(ua % ub), 32'(ua / ub)};
        end
        3'd5: m_hi = x;
        3'd6: m_lo = x;
        3'd7: if (MADD) begin m_res = {m_hi, m_lo} + 64'(sa * sb); m_left = NM; end
        default: ;
      endcase
    end
    #1;
    chk("busy", {63'd0, busy}, {63'd0, m_left > 0});
    chk("hi", {32'd0, hi}, {32'd0, m_hi});
    chk("lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  // Issue one op and count the busy cycles that follow (bounded).
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit d, input int exp_n);
    int n = 0;
    step(1'b1, o, x, y, d);
    for (int i = 0; i < 20 && busy; i++) begin
      n++;
      step(1'b0, 3'd0, 32'd0, 32'd0, d);
    end
    chk("latency", 64'(n), 64'(exp_n));
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset_n = 1'b0; start = 0; op = 0; a = 0; b = 0; d_uses_md = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk) reset_n = 1'b1;

    // mult -3 * 5
    run_op(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0, 5);
    chk("mult_hi", {32'd0, hi}, 64'hFFFFFFFF);
    chk("mult_lo", {32'd0, lo}, 64'hFFFFFFF1);
    // multu
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 5);
    chk("multu_hi", {32'd0, hi}, 64'h1);
    chk("multu_lo", {32'd0, lo}, 64'hFFFFFFFE);
    // div -7 / 2
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 10);
    chk("div_hi", {32'd0, hi}, 64'hFFFFFFFF);
    chk("div_lo", {32'd0, lo}, 64'hFFFFFFFD);
    // INT_MIN / -1
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10);
    chk("ovf_hi", {32'd0, hi}, 64'h0);
    chk("ovf_lo", {32'd0, lo}, 64'h80000000);
    // divu by zero leaves preloaded values
    step(1'b1, 3'd5, 32'h11, 32'd0, 1'b0);
    step(1'b1, 3'd6, 32'h22, 32'd0, 1'b0);
    run_op(3'd4, 32'd7, 32'd0, 1'b0, 10);
    chk("dz_hi", {32'd0, hi}, 64'h11);
    chk("dz_lo", {32'd0, lo}, 64'h22);

    // back-to-back: second start ignored, stall held
    step(1'b1, 3'd1, 32'd6, 32'd7, 1'b1);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    step(1'b1, 3'd1, 32'd9, 32'd9, 1'b1);
    for (int i = 0; i < 20 && busy; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    chk("b2b_hi", {32'd0, hi}, 64'h0);
    chk("b2b_lo", {32'd0, lo}, 64'd42);

    // reset in the middle of a div
    step(1'b1, 3'd3, 32'd100, 32'd3, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_hi", {32'd0, hi}, 64'd0);
    chk("arst_lo", {32'd0, lo}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    model_reset();
    @(negedge clk) reset_n = 1'b1;
    repeat (12) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    chk("arst_wb_lo", {32'd0, lo}, 64'd0);

    // madd (or no-op when the option is absent)
    step(1'b1, 3'd5, 32'd0, 32'd0, 1'b0);
    step(1'b1, 3'd6, 32'd10, 32'd0, 1'b0);
    run_op(3'd7, 32'd3, 32'd4, 1'b1, MADD ? 5 : 0);
    chk("madd_lo", {32'd0, lo}, MADD ? 64'd22 : 64'd10);
    chk("madd_hi", {32'd0, hi}, 64'd0);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = $urandom_range(0, 9);
        default: ;
      endcase
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ra, rb, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time limit
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
